// File: rtl/vm_pkg.sv
// Shared vending-machine types: coin bus encoding, change-dispenser states
// and the value of each coin in 5-cent units.
package vm_pkg;

  // Coin bus encoding, common to the coin acceptor and the change dispenser.
  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_NICKEL = 2'b01,
    COIN_DIME   = 2'b10
  } coin_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPENSE,
    ST_DONE,
    ST_ERROR
  } chg_state_t;

  localparam int NICKEL_UNITS = 1;
  localparam int DIME_UNITS   = 2;

endpackage

// File: rtl/coin_stock.sv
// Stock counter for one coin denomination: loads INIT on reset, counts up on
// refill (saturating at all-ones), counts down on dispense (never below zero).
// Simultaneous inc and dec cancel out.
module coin_stock #(
  parameter int STOCK_W = 6,
  parameter int INIT    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  output logic [STOCK_W-1:0] cnt
);

  localparam logic [STOCK_W-1:0] CNT_MAX  = '1;
  localparam logic [STOCK_W-1:0] CNT_INIT = STOCK_W'(INIT);
  localparam logic [STOCK_W-1:0] CNT_ONE  = STOCK_W'(1);

  // Stock register: reload on reset, otherwise apply refill/dispense.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CNT_INIT;
    end else begin
      case ({inc, dec})
        2'b10:   if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
        2'b01:   if (cnt != '0)      cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change request in 5-cent units, picks the
// greedy dime-first coin mix against current stock, rejects requests that
// cannot be paid exactly, and streams the coins out with valid/ready.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W        = 4,
  parameter int STOCK_W      = 6,
  parameter int INIT_NICKELS = 8,
  parameter int INIT_DIMES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amt,
  output logic               req_ready,
  output logic               coin_valid,
  output logic [1:0]         coin,
  input  logic               coin_ready,
  output logic               done,
  output logic               err,
  input  logic               refill_nickel,
  input  logic               refill_dime,
  output logic [STOCK_W-1:0] nickel_cnt,
  output logic [STOCK_W-1:0] dime_cnt
);

  // Common width for comparing amounts against stock counts.
  localparam int CW = (STOCK_W > AMT_W) ? STOCK_W : AMT_W;
  localparam logic [AMT_W-1:0] DIME_U = AMT_W'(DIME_UNITS);
  localparam logic [AMT_W:0]   ONE_COIN = (AMT_W+1)'(1);

  chg_state_t       state, state_nxt;
  logic [AMT_W-1:0] amt_q, amt_nxt;
  logic [AMT_W-1:0] dimes_left, dimes_left_nxt;
  logic [AMT_W-1:0] nickels_left, nickels_left_nxt;
  logic [CW-1:0]    half_amt, dime_avail, d_use_w;
  logic [AMT_W-1:0] d_use, n_use;
  logic             xfer, dec_dime, dec_nickel;
  coin_t            coin_c;

  // Greedy mix: as many dimes as stock and amount allow, nickels for the rest.
  always_comb begin
    half_amt   = CW'(amt_q >> 1);
    dime_avail = CW'(dime_cnt);
    d_use_w    = (dime_avail < half_amt) ? dime_avail : half_amt;
    d_use      = AMT_W'(d_use_w);
    n_use      = amt_q - d_use * DIME_U;
  end

  assign xfer       = coin_valid & coin_ready;
  assign dec_dime   = xfer && (dimes_left != '0);
  assign dec_nickel = xfer && (dimes_left == '0);

  // Control registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      amt_q        <= '0;
      dimes_left   <= '0;
      nickels_left <= '0;
    end else begin
      state        <= state_nxt;
      amt_q        <= amt_nxt;
      dimes_left   <= dimes_left_nxt;
      nickels_left <= nickels_left_nxt;
    end
  end

  // Next-state, mix loading and per-state outputs.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt        = state;
    amt_nxt          = amt_q;
    dimes_left_nxt   = dimes_left;
    nickels_left_nxt = nickels_left;
    req_ready        = 1'b0;
    coin_valid       = 1'b0;
    coin_c           = COIN_NONE;
    done             = 1'b0;
    err              = 1'b0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          amt_nxt   = req_amt;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (amt_q == '0) begin
          state_nxt = ST_DONE;
        end else if (CW'(n_use) > CW'(nickel_cnt)) begin
          state_nxt = ST_ERROR;
        end else begin
          dimes_left_nxt   = d_use;
          nickels_left_nxt = n_use;
          state_nxt        = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        coin_valid = 1'b1;
        coin_c     = (dimes_left != '0) ? COIN_DIME : COIN_NICKEL;
        if (xfer) begin
          if (dimes_left != '0) dimes_left_nxt   = dimes_left - AMT_W'(1);
          else                  nickels_left_nxt = nickels_left - AMT_W'(1);
          if (({1'b0, dimes_left} + {1'b0, nickels_left}) == ONE_COIN)
            state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        err       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign coin = coin_c;

  coin_stock #(.STOCK_W(STOCK_W), .INIT(INIT_NICKELS)) u_nickel_stock (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_nickel),
    .dec   (dec_nickel),
    .cnt   (nickel_cnt)
  );

  coin_stock #(.STOCK_W(STOCK_W), .INIT(INIT_DIMES)) u_dime_stock (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_dime),
    .dec   (dec_dime),
    .cnt   (dime_cnt)
  );

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser: reset, greedy mix, backpressure,
// stock-limited mixes, rejection, zero request, refill saturation,
// refill/dispense collision and reset mid-dispense.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_amt;
  logic       req_ready;
  logic       coin_valid;
  logic [1:0] coin;
  logic       coin_ready;
  logic       done;
  logic       err;
  logic       refill_nickel;
  logic       refill_dime;
  logic [5:0] nickel_cnt;
  logic [5:0] dime_cnt;

  int tests = 0;
  int fails = 0;

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_amt       (req_amt),
    .req_ready     (req_ready),
    .coin_valid    (coin_valid),
    .coin          (coin),
    .coin_ready    (coin_ready),
    .done          (done),
    .err           (err),
    .refill_nickel (refill_nickel),
    .refill_dime   (refill_dime),
    .nickel_cnt    (nickel_cnt),
    .dime_cnt      (dime_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Present a request for one cycle; returns in cycle T+1.
  task automatic start_req(input logic [3:0] amt);
    req_valid = 1'b1;
    req_amt   = amt;
    step();
    req_valid = 1'b0;
    req_amt   = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_amt       = 4'd0;
    coin_ready    = 1'b0;
    refill_nickel = 1'b0;
    refill_dime   = 1'b0;

    // 1. Reset held two cycles
    step();
    step();
    check("rst_req_ready",  req_ready,  1);
    check("rst_coin_valid", coin_valid, 0);
    check("rst_coin",       coin,       0);
    check("rst_done",       done,       0);
    check("rst_err",        err,        0);
    check("rst_nickel",     nickel_cnt, 8);
    check("rst_dime",       dime_cnt,   8);
    reset = 1'b0;

    // 2. amt=3 -> dime then nickel, done at T+4
    coin_ready = 1'b1;
    start_req(4'd3);
    check("t2_check_ready", req_ready,  0);
    check("t2_check_valid", coin_valid, 0);
    step();
    check("t2_c0_valid",    coin_valid, 1);
    check("t2_c0_coin",     coin,       2);
    step();
    check("t2_c1_coin",     coin,       1);
    check("t2_c1_dime",     dime_cnt,   7);
    step();
    check("t2_done",        done,       1);
    check("t2_done_valid",  coin_valid, 0);
    check("t2_end_nickel",  nickel_cnt, 7);
    check("t2_end_dime",    dime_cnt,   7);
    step();
    check("t2_done_pulse",  done,       0);
    check("t2_idle_ready",  req_ready,  1);

    // 3. Backpressure: amt=4, three stalled cycles
    do_reset();
    coin_ready = 1'b0;
    start_req(4'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall_valid", coin_valid, 1);
      check("t3_stall_coin",  coin,       2);
      check("t3_stall_dime",  dime_cnt,   8);
    end
    coin_ready = 1'b1;
    step();
    check("t3_c1_coin",     coin,       2);
    check("t3_c1_dime",     dime_cnt,   7);
    step();
    check("t3_done",        done,       1);
    check("t3_end_dime",    dime_cnt,   6);
    check("t3_end_nickel",  nickel_cnt, 8);
    step();

    // 4a. Drain dimes to 1 with amt=14, then amt=5 -> 10,01,01,01
    do_reset();
    start_req(4'd14);
    step();
    for (int i = 0; i < 7; i++) begin
      check("t4_drain_coin", coin, 2);
      step();
    end
    check("t4_drain_done",  done,     1);
    check("t4_drain_dime",  dime_cnt, 1);
    step();
    start_req(4'd5);
    step();
    check("t4_c0_coin", coin, 2);
    step();
    check("t4_c1_coin", coin, 1);
    step();
    check("t4_c2_coin", coin, 1);
    step();
    check("t4_c3_coin", coin, 1);
    check("t4_c3_valid", coin_valid, 1);
    step();
    check("t4_done",       done,       1);
    check("t4_end_nickel", nickel_cnt, 5);
    check("t4_end_dime",   dime_cnt,   0);
    step();

    // 4b. No nickels, amt=3 needs one -> rejected
    do_reset();
    for (int i = 0; i < 8; i++) begin
      start_req(4'd1);
      step();
      check("t4b_nick_coin", coin, 1);
      step();
      step();
    end
    check("t4b_nickel0", nickel_cnt, 0);
    check("t4b_dime8",   dime_cnt,   8);
    start_req(4'd3);
    check("t4b_check_valid", coin_valid, 0);
    step();
    check("t4b_err",        err,        1);
    check("t4b_err_valid",  coin_valid, 0);
    check("t4b_err_done",   done,       0);
    check("t4b_err_nickel", nickel_cnt, 0);
    check("t4b_err_dime",   dime_cnt,   8);
    step();
    check("t4b_err_pulse",  err,        0);
    check("t4b_err_ready",  req_ready,  1);

    // 5. Zero request, dime refill saturation, refill/dispense collision
    start_req(4'd0);
    check("t5_zero_valid0", coin_valid, 0);
    step();
    check("t5_zero_done",   done,       1);
    check("t5_zero_valid",  coin_valid, 0);
    step();
    refill_dime = 1'b1;
    repeat (54) step();
    check("t5_dime62", dime_cnt, 62);
    repeat (3) step();
    check("t5_dime_sat", dime_cnt, 63);
    refill_dime = 1'b0;
    step();
    check("t5_dime_hold", dime_cnt, 63);
    refill_nickel = 1'b1;
    step();
    step();
    refill_nickel = 1'b0;
    check("t5_nickel2", nickel_cnt, 2);
    start_req(4'd1);
    step();
    check("t5_coll_coin", coin, 1);
    refill_nickel = 1'b1;
    step();
    refill_nickel = 1'b0;
    check("t5_coll_nickel", nickel_cnt, 2);
    check("t5_coll_done",   done,       1);
    step();

    // 6. Reset after the first coin of amt=6
    do_reset();
    start_req(4'd6);
    step();
    check("t6_c0_coin", coin, 2);
    step();
    check("t6_c1_dime", dime_cnt, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_valid",  coin_valid, 0);
    check("t6_rst_done",   done,       0);
    check("t6_rst_ready",  req_ready,  1);
    check("t6_rst_nickel", nickel_cnt, 8);
    check("t6_rst_dime",   dime_cnt,   8);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_done",  done,       0);
      check("t6_no_valid", coin_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Returns change after a vending transaction.
- Accepts a change request in 5-cent units and emits a sequence of coins on a 2-bit coin bus. The coin encoding is the same one the coin acceptor consumes: 00 none, 01 nickel (1 unit), 10 dime (2 units).
- Keeps on-chip stock counters for nickels and dimes, dispenses dimes first, and rejects any request the current stock cannot pay exactly.

Parameters:
- AMT_W, 4, width of the request amount in 5-cent units (max 15).
- STOCK_W, 6, width of each stock counter; saturates at 2**STOCK_W-1.
- INIT_NICKELS, 8, nickel stock loaded at reset.
- INIT_DIMES, 8, dime stock loaded at reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  change request present.
- req_amt  input  AMT_W  change owed, in 5-cent units.
- req_ready  output  1  high when a request can be accepted (state IDLE).
- coin_valid  output  1  coin on the coin bus is valid.
- coin  output  2  coin code: 00 none, 01 nickel, 10 dime.
- coin_ready  input  1  downstream takes the coin this cycle.
- done  output  1  one-cycle pulse: request fully paid.
- err  output  1  one-cycle pulse: request rejected, nothing dispensed.
- refill_nickel  input  1  adds one nickel to stock per cycle while high.
- refill_dime  input  1  adds one dime to stock per cycle while high.
- nickel_cnt  output  STOCK_W  current nickel stock.
- dime_cnt  output  STOCK_W  current dime stock.

Behaviour:
- Reset (synchronous, active-high, clk domain): takes effect at the clk edge where reset=1.
  - state=IDLE; coin_valid=0; coin=00; done=0; err=0; req_ready=1.
  - nickel_cnt=INIT_NICKELS; dime_cnt=INIT_DIMES.
  - Reset mid-dispense aborts the request: no further coins, no done, stock reloaded to INIT values.
- States: IDLE, CHECK, DISPENSE, DONE, ERROR.
- IDLE: req_ready=1. On req_valid, latch req_amt and go to CHECK (accept cycle T).
- CHECK (T+1) decides the coin mix and registers it:
  - d_use = min(dime_cnt, amt>>1); n_use = amt - 2*d_use.
  - amt==0 -> DONE.
  - n_use > nickel_cnt -> ERROR.
  - Otherwise load dimes_left=d_use, nickels_left=n_use, go to DISPENSE.
  - This greedy mix is the required selection: it maximises dimes used.
- DISPENSE (from T+2):
  - coin_valid=1; coin=10 while dimes_left>0, else 01.
  - A coin is transferred when coin_valid & coin_ready.
  - On transfer: decrement the matching left-count and the matching stock counter.
  - coin is held stable while coin_ready=0.
  - After the transfer of the last coin, go to DONE.
  - No idle cycle is inserted between consecutive coins.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERROR: err=1 for exactly one cycle; stock unchanged; then IDLE.
- Latency: first coin at T+2. For amt==0 or a rejected request, done/err asserts at T+2. New request accepted at the earliest in the cycle after done/err.
- Stock counters:
  - Refill is accepted in every state.
  - Increments saturate at max.
  - Refill and dispense of the same denomination in the same cycle: count unchanged.
  - Stock never decrements below 0; CHECK guarantees this.
  - Refill during CHECK/DISPENSE does not change the already-decided mix.
- req_valid while not IDLE is ignored (req_ready=0).
- Stray coin_ready while coin_valid=0 has no effect.

Decomposition:
- Package vm_pkg:
  - coin_t enum: COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b10; shared with the coin acceptor.
  - chg_state_t enum.
  - Unit constants: NICKEL_UNITS=1, DIME_UNITS=2.
- Sub-module coin_stock: saturating up/down counter with parameters STOCK_W and INIT, and inputs inc, dec. Instantiated twice (nickel, dime).

Test Plan:
1. Reset: hold reset 2 cycles -> req_ready=1, coin_valid=0, coin=00, done=0, err=0, nickel_cnt=8, dime_cnt=8.
2. req_amt=3, coin_ready=1 -> coin=10 at T+2, coin=01 at T+3, done at T+4; counts end at nickel_cnt=7, dime_cnt=7.
3. Backpressure: req_amt=4, coin_ready=0 for 3 cycles, then 1 -> coin=10 stable while stalled, then two dimes total, done, dime_cnt=6, nickel_cnt=8.
4. Stock limit and rejection:
   - Dimes drained to 1, nickel_cnt=8, req_amt=5 -> coins 10,01,01,01, done.
   - nickel_cnt=0, dime_cnt=8, req_amt=3 -> err at T+2, no coin_valid, counts unchanged.
5. Zero and refill: req_amt=0 -> done at T+2, no coins. refill_dime held high with dime_cnt=62 for 3 cycles -> saturates at 63. refill_nickel coincident with a nickel transfer -> nickel_cnt unchanged.
6. Reset mid-dispense: req_amt=6, assert reset after the first coin -> coin_valid=0 next cycle, no done, counts=8/8, req_ready=1.
